// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: runs a req/gnt/rvalid handshake with a variable-latency
// data memory, stalls the pipeline while busy and returns load bytes left-aligned at [31:24].
module mem_access_unit #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 15
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_req_valid,
  input  logic [9:0]      i_operation,
  input  logic [XLEN-1:0] i_addr,
  input  logic [XLEN-1:0] i_wdata,
  output logic            o_stall,
  output logic            o_done,
  output logic [31:0]     o_mem_data,
  output logic            o_misaligned,
  output logic            o_bus_error,
  output logic            o_mem_req,
  output logic            o_mem_we,
  output logic [XLEN-1:0] o_mem_addr,
  output logic [3:0]      o_mem_be,
  output logic [31:0]     o_mem_wdata,
  input  logic            i_mem_gnt,
  input  logic            i_mem_rvalid,
  input  logic [31:0]     i_mem_rdata,
  output logic [1:0]      o_state
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REQ    = 2'd1;
  localparam logic [1:0] S_WAIT_R = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  logic [1:0]      r_state;
  logic [CW-1:0]   r_cnt;
  logic [1:0]      r_offset;
  logic            r_stall;
  logic            r_done;
  logic            r_misaligned;
  logic            r_bus_error;
  logic            r_mem_req;
  logic            r_mem_we;
  logic [XLEN-1:0] r_mem_addr;
  logic [3:0]      r_mem_be;
  logic [31:0]     r_mem_wdata;
  logic [31:0]     r_mem_data;

  logic [2:0]      w_funct3;
  logic [6:0]      w_opcode;
  logic            w_is_load;
  logic            w_is_store;
  logic            w_legal;
  logic            w_misalign;
  logic [3:0]      w_be;
  logic [31:0]     w_wdata;
  logic [31:0]     w_load_data;

  assign w_funct3   = i_operation[9:7];
  assign w_opcode   = i_operation[6:0];
  assign w_is_load  = (w_opcode == OP_LOAD);
  assign w_is_store = (w_opcode == OP_STORE);

  // Halfwords need addr[0]==0, words need addr[1:0]==0; bytes are always aligned.
  assign w_misalign = ((w_funct3[1:0] == 2'b01) & i_addr[0]) |
                      ((w_funct3[1:0] == 2'b10) & (|i_addr[1:0]));

  // Loaded word is shifted so the addressed byte lands in [31:24], zero-filled below.
  assign w_load_data = i_mem_rdata << {r_offset, 3'b000};

  always_comb begin
    w_legal = 1'b0;
    w_be    = 4'b1111;
    w_wdata = i_wdata[31:0];
    case (w_funct3)
      3'b000, 3'b001, 3'b010: w_legal = w_is_load | w_is_store;
      3'b100, 3'b101:         w_legal = w_is_load;
      default:                w_legal = 1'b0;
    endcase
    if (w_is_store) begin
      case (w_funct3[1:0])
        2'b00: begin
          w_be    = 4'b1000 >> i_addr[1:0];
          w_wdata = {4{i_wdata[7:0]}};
        end
        2'b01: begin
          w_be    = i_addr[1] ? 4'b0011 : 4'b1100;
          w_wdata = {2{i_wdata[15:0]}};
        end
        default: begin
          w_be    = 4'b1111;
          w_wdata = i_wdata[31:0];
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_offset     <= 2'b00;
      r_stall      <= 1'b0;
      r_done       <= 1'b0;
      r_misaligned <= 1'b0;
      r_bus_error  <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_be     <= 4'b0000;
      r_mem_wdata  <= '0;
      r_mem_data   <= '0;
    end else begin
      r_done       <= 1'b0;
      r_misaligned <= 1'b0;
      r_bus_error  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_req_valid && w_legal) begin
            if (w_misalign) begin
              r_misaligned <= 1'b1;
            end else begin
              r_mem_addr  <= {i_addr[XLEN-1:2], 2'b00};
              r_mem_be    <= w_be;
              r_mem_wdata <= w_wdata;
              r_mem_we    <= w_is_store;
              r_offset    <= i_addr[1:0];
              r_mem_req   <= 1'b1;
              r_stall     <= 1'b1;
              r_state     <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (i_mem_gnt) begin
            r_mem_req <= 1'b0;
            if (r_mem_we) begin
              r_state <= S_DONE;
            end else begin
              r_cnt   <= '0;
              r_state <= S_WAIT_R;
            end
          end
        end
        S_WAIT_R: begin
          // A response on the final counted cycle still completes the load.
          if (i_mem_rvalid) begin
            r_mem_data <= w_load_data;
            r_state    <= S_DONE;
          end else if (r_cnt == CNT_LAST) begin
            r_bus_error <= 1'b1;
            r_stall     <= 1'b0;
            r_state     <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_stall <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_state      = r_state;
  assign o_stall      = r_stall;
  assign o_done       = r_done;
  assign o_mem_data   = r_mem_data;
  assign o_misaligned = r_misaligned;
  assign o_bus_error  = r_bus_error;
  assign o_mem_req    = r_mem_req;
  assign o_mem_we     = r_mem_we;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_be     = r_mem_be;
  assign o_mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: each transaction is turned into a per-cycle expected timeline
// from its latency rules, and one compare process checks every output on every cycle.
module tb_mem_access_unit;

  localparam int TIMEOUT = 15;
  localparam int N       = 4096;

  // Handshake: a request is sampled only when the unit is idle; mem_req stays high
  // with stable fields until mem_gnt, loads then wait for mem_rvalid or time out.

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic [9:0]  operation;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall, done, misaligned, bus_error;
  logic [31:0] mem_data;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  logic [1:0]  state;

  mem_access_unit #(.XLEN(32), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_req_valid(req_valid), .i_operation(operation),
    .i_addr(addr), .i_wdata(wdata), .o_stall(stall), .o_done(done),
    .o_mem_data(mem_data), .o_misaligned(misaligned), .o_bus_error(bus_error),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_be(mem_be),
    .o_mem_wdata(mem_wdata), .i_mem_gnt(mem_gnt), .i_mem_rvalid(mem_rvalid),
    .i_mem_rdata(mem_rdata), .o_state(state)
  );

  // ---------------- clock / reset ----------------
  int cyc = 0;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc++;

  // ---------------- expected timeline ----------------
  bit        e_stall [N];
  bit        e_done  [N];
  bit        e_mis   [N];
  bit        e_berr  [N];
  bit        e_req   [N];
  bit        e_we    [N];
  bit [31:0] e_addr  [N];
  bit [3:0]  e_be    [N];
  bit [31:0] e_wd    [N];
  bit        e_dset  [N];
  bit [31:0] e_dval  [N];

  int n_cmp = 0;
  int n_err = 0;
  bit sim_done = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit [3:0] m_be(input bit [2:0] f3, input bit st, input bit [1:0] off);
    int n;
    bit [3:0] be;
    n  = 1 << f3[1:0];
    be = 4'b0000;
    if (!st) return 4'b1111;
    for (int i = 0; i < 4; i++)
      if (i >= int'(off) && i < int'(off) + n) be[3-i] = 1'b1;
    return be;
  endfunction

  function automatic bit [31:0] m_wd(input bit [2:0] f3, input bit [31:0] wd);
    int n;
    bit [31:0] w;
    n = 1 << f3[1:0];
    w = '0;
    for (int i = 0; i < 4; i++) w[31-8*i -: 8] = wd[8*(n-1-(i%n)) +: 8];
    return w;
  endfunction

  function automatic bit [31:0] m_ld(input bit [31:0] rd, input bit [1:0] off);
    return rd << (8 * int'(off));
  endfunction

  // ---------------- compare process ----------------
  initial begin
    logic [31:0] cur_data;
    int t;
    cur_data = '0;
    while (!sim_done) begin
      @(posedge clk);
      #1;
      if (!sim_done && cyc >= 1 && cyc < N) begin
        t = cyc;
        if (e_dset[t]) cur_data = e_dval[t];
        chk("stall",      {31'b0, stall},      {31'b0, e_stall[t]});
        chk("done",       {31'b0, done},       {31'b0, e_done[t]});
        chk("misaligned", {31'b0, misaligned}, {31'b0, e_mis[t]});
        chk("bus_error",  {31'b0, bus_error},  {31'b0, e_berr[t]});
        chk("mem_req",    {31'b0, mem_req},    {31'b0, e_req[t]});
        chk("mem_data",   mem_data,            cur_data);
        if (e_req[t]) begin
          chk("mem_addr", mem_addr,             e_addr[t]);
          chk("mem_be",   {28'b0, mem_be},      {28'b0, e_be[t]});
          chk("mem_we",   {31'b0, mem_we},      {31'b0, e_we[t]});
          if (e_we[t]) chk("mem_wdata", mem_wdata, e_wd[t]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_edge(input bit rv, input bit [9:0] op, input bit [31:0] ad,
                            input bit [31:0] wd, input bit gnt, input bit rvl,
                            input bit [31:0] rd);
    req_valid  = rv;
    operation  = op;
    addr       = ad;
    wdata      = wd;
    mem_gnt    = gnt;
    mem_rvalid = rvl;
    mem_rdata  = rd;
    @(negedge clk);
  endtask

  // r < 0 means the response is never sent.
  task automatic run_txn(input bit [2:0] f3, input bit st, input bit is_mem,
                         input bit [31:0] ad, input bit [31:0] wd,
                         input int g, input int r, input bit [31:0] rd);
    int a, e, gg, n, n_idle;
    bit [6:0] opc;
    bit legal, mis, rvl, gnt;
    a   = cyc + 1;
    opc = !is_mem ? 7'b0110011 : (st ? 7'b0100011 : 7'b0000011);
    legal = is_mem && (st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}));
    n   = 1 << f3[1:0];
    mis = (int'(ad[1:0]) % n) != 0;
    e   = a;
    gg  = a + 1 + g;
    if (legal && mis) begin
      e_mis[a] = 1'b1;
    end else if (legal) begin
      for (int t = a; t <= a + g; t++) begin
        e_req[t]  = 1'b1;
        e_addr[t] = {ad[31:2], 2'b00};
        e_be[t]   = m_be(f3, st, ad[1:0]);
        e_we[t]   = st;
        e_wd[t]   = m_wd(f3, wd);
      end
      if (st) begin
        e = a + g + 2;
        for (int t = a; t < e; t++) e_stall[t] = 1'b1;
        e_done[e] = 1'b1;
      end else if (r >= 0 && r < TIMEOUT) begin
        e = gg + r + 2;
        for (int t = a; t < e; t++) e_stall[t] = 1'b1;
        e_dset[gg + r + 1] = 1'b1;
        e_dval[gg + r + 1] = m_ld(rd, ad[1:0]);
        e_done[e] = 1'b1;
      end else begin
        e = gg + TIMEOUT;
        for (int t = a; t < e; t++) e_stall[t] = 1'b1;
        e_berr[e] = 1'b1;
      end
    end
    drive_edge(1'b1, {f3, opc}, ad, wd, 1'b0, 1'b0, $urandom);
    for (int t = a + 1; t <= e; t++) begin
      gnt = (t == gg) ? 1'b1 : ((t > gg) ? 1'($urandom_range(0, 1)) : 1'b0);
      if (!st && t > gg) rvl = (r >= 0 && r < TIMEOUT && t == gg + 1 + r);
      else               rvl = 1'($urandom_range(0, 1));
      drive_edge(1'($urandom_range(0, 1)), 10'($urandom), $urandom, $urandom, gnt, rvl,
                 (!st && t == gg + 1 + r) ? rd : $urandom);
    end
    n_idle = 1 + $urandom_range(0, 2);
    for (int k = 0; k < n_idle; k++)
      drive_edge(1'b0, 10'($urandom), $urandom, $urandom, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), $urandom);
  endtask

  // Load granted at once, then reset pulled low two cycles into the wait.
  task automatic reset_in_wait();
    int a, x;
    a = cyc + 1;
    x = a + 3;
    e_req[a]  = 1'b1;
    e_addr[a] = 32'h400;
    e_be[a]   = 4'b1111;
    e_we[a]   = 1'b0;
    for (int t = a; t < x; t++) e_stall[t] = 1'b1;
    e_dset[x] = 1'b1;
    e_dval[x] = 32'h0;
    drive_edge(1'b1, {3'b010, 7'b0000011}, 32'h400, 32'h0, 1'b0, 1'b0, 32'h0);
    drive_edge(1'b0, 10'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    drive_edge(1'b0, 10'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    rst_n = 1'b0;
    drive_edge(1'b0, 10'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    rst_n = 1'b1;
    chk("rst_mem_data", mem_data, 32'h0);
    drive_edge(1'b0, 10'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hCAFEF00D);
    drive_edge(1'b0, 10'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hCAFEF00D);
    drive_edge(1'b0, 10'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit [2:0] ld_f3 [5];
    bit [2:0] f3;
    bit       st, is_mem;
    int       g, r, pick;
    ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    rst_n = 1'b0;
    req_valid = 1'b0; operation = '0; addr = '0; wdata = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    e_dset[1] = 1'b1;
    e_dval[1] = 32'h0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    chk("pin_be_sb",  {28'b0, m_be(3'd0, 1'b1, 2'd3)}, 32'h1);
    chk("pin_be_sh",  {28'b0, m_be(3'd1, 1'b1, 2'd2)}, 32'h3);
    chk("pin_wd_sb",  m_wd(3'd0, 32'h000000A5), 32'hA5A5A5A5);
    chk("pin_wd_sh",  m_wd(3'd1, 32'h00001234), 32'h12341234);
    chk("pin_ld_lb",  m_ld(32'h11223344, 2'd1), 32'h22334400);

    run_txn(3'd2, 1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 0, 0, 32'h0);
    run_txn(3'd0, 1'b1, 1'b1, 32'h103, 32'h000000A5, 0, 0, 32'h0);
    run_txn(3'd1, 1'b1, 1'b1, 32'h102, 32'h00001234, 1, 0, 32'h0);
    run_txn(3'd0, 1'b0, 1'b1, 32'h201, 32'h0, 2, 2, 32'h11223344);
    chk("lb_literal", mem_data, 32'h22334400);
    run_txn(3'd2, 1'b0, 1'b1, 32'h202, 32'h0, 0, 0, 32'h0);
    run_txn(3'd1, 1'b0, 1'b1, 32'h203, 32'h0, 0, 0, 32'h0);
    run_txn(3'd2, 1'b0, 1'b1, 32'h300, 32'h0, 0, -1, 32'h0);
    chk("timeout_hold", mem_data, 32'h22334400);
    run_txn(3'd2, 1'b0, 1'b1, 32'h304, 32'h0, 1, TIMEOUT - 1, 32'h89ABCDEF);
    chk("late_rvalid_wins", mem_data, 32'h89ABCDEF);
    run_txn(3'd2, 1'b0, 1'b0, 32'h308, 32'h0, 0, 0, 32'h0);
    run_txn(3'd5, 1'b0, 1'b1, 32'h30A, 32'h0, 0, 1, 32'h5566AABB);
    reset_in_wait();

    for (int k = 0; k < 80; k++) begin
      is_mem = ($urandom_range(0, 9) != 0);
      st     = 1'($urandom_range(0, 1));
      f3     = st ? 3'($urandom_range(0, 2)) : ld_f3[$urandom_range(0, 4)];
      g      = $urandom_range(0, 3);
      pick   = $urandom_range(0, 5);
      r      = (pick == 0) ? -1 : ((pick == 1) ? int'($urandom_range(0, TIMEOUT - 1))
                                               : int'($urandom_range(0, 3)));
      run_txn(f3, st, is_mem, $urandom, $urandom, g, r, $urandom);
    end

    repeat (3) @(negedge clk);
    sim_done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
